// File: rtl/mmmu_bridge_arb_if.sv
// Bus bundle between mmmu_bridge_arb and its requesters plus the bridge arb port.
// master is the arbiter's view and slave is the environment's view.
package mmmu_arb_pkg;
  typedef logic [3:0] dbus_meta_t;
endpackage

interface mmmu_bridge_arb_if #(parameter int NUM_REQ = 4);
  import mmmu_arb_pkg::*;

  logic [NUM_REQ-1:0]       req_vld_i;
  logic [NUM_REQ-1:0][31:0] req_pkt_i;
  logic [NUM_REQ-1:0]       req_ack_o;
  logic [NUM_REQ-1:0]       req_fin_o;
  logic [NUM_REQ-1:0]       rsp_vld_o;
  logic [31:0]              rsp_pkt_o;
  dbus_meta_t               rsp_type_o;
  logic [NUM_REQ-1:0]       grant_o;
  logic                     arb_vld_o;
  logic [31:0]              arb_pkt_o;
  logic                     arb_ack_i;
  logic                     arb_fin_i;
  logic                     arb_rsp_vld_i;
  logic [31:0]              arb_rsp_pkt_i;
  dbus_meta_t               arb_rsp_type_i;
  logic                     stray_rsp_o;
  logic                     timeout_o;

  modport master (
    input  req_vld_i, req_pkt_i, arb_ack_i, arb_fin_i,
           arb_rsp_vld_i, arb_rsp_pkt_i, arb_rsp_type_i,
    output req_ack_o, req_fin_o, rsp_vld_o, rsp_pkt_o, rsp_type_o,
           grant_o, arb_vld_o, arb_pkt_o, stray_rsp_o, timeout_o
  );

  modport slave (
    output req_vld_i, req_pkt_i, arb_ack_i, arb_fin_i,
           arb_rsp_vld_i, arb_rsp_pkt_i, arb_rsp_type_i,
    input  req_ack_o, req_fin_o, rsp_vld_o, rsp_pkt_o, rsp_type_o,
           grant_o, arb_vld_o, arb_pkt_o, stray_rsp_o, timeout_o
  );
endinterface

// File: rtl/mmmu_bridge_arb.sv
// Round-robin arbiter sharing the mmmu_bridge arb port among NUM_REQ requesters.
// Optional watchdog abort is built only when MMMU_ARB_TIMEOUT_EN is defined.
module mmmu_bridge_arb
  import mmmu_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  mmmu_bridge_arb_if.master bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 2) begin : g_param_chk
    $error("mmmu_bridge_arb: parameter out of range");
  end

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_FIN = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [IDX_W-1:0]   rr_ptr_r;
  logic [IDX_W-1:0]   gnt_idx_r;
  logic [IDX_W-1:0]   sel_idx_s;
  logic               sel_found_s;
  logic [31:0]        pkt_r;
  logic [NUM_REQ-1:0] grant_r;
  logic               arb_vld_r;
  logic               stray_r;
  logic               abort_s;
  logic               done_s;

  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    else              s = s;
    return IDX_W'(s);
  endfunction

  // Round-robin pick: walking the offsets downward leaves the nearest requester from rr_ptr_r.
  always_comb begin
    sel_found_s = 1'b0;
    sel_idx_s   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (bus.req_vld_i[wrap_idx(rr_ptr_r, k)]) begin
        sel_found_s = 1'b1;
        sel_idx_s   = wrap_idx(rr_ptr_r, k);
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

`ifdef MMMU_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
  logic [CNT_W-1:0] cnt_r;
  logic             timeout_r;

  // Watchdog count held at zero while idle, so it reads zero on the first ISSUE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt_r <= '0;
    else if (state_r == IDLE)  cnt_r <= '0;
    else                       cnt_r <= cnt_r + CNT_W'(1);
  end

  // A fin on the limit cycle wins over the abort.
  assign abort_s = (state_r != IDLE) && !bus.arb_fin_i && (cnt_r == CNT_W'(TIMEOUT_CYC - 1));

  // Sticky watchdog flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) timeout_r <= 1'b0;
    else        timeout_r <= timeout_r | abort_s;
  end

  assign bus.timeout_o = timeout_r;
`else
  assign abort_s       = 1'b0;
  assign bus.timeout_o = 1'b0;
`endif

  assign done_s = (state_r != IDLE) && (bus.arb_fin_i || abort_s);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_nxt_s;
  end

  // Next-state logic; fin alone in ISSUE also ends the transaction.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:     state_nxt_s = sel_found_s ? ISSUE : IDLE;
      ISSUE: begin
        if (done_s)                 state_nxt_s = IDLE;
        else if (bus.arb_ack_i)     state_nxt_s = WAIT_FIN;
        else                        state_nxt_s = ISSUE;
      end
      WAIT_FIN: state_nxt_s = done_s ? IDLE : WAIT_FIN;
      default:  state_nxt_s = IDLE;
    endcase
  end

  // Combinational outputs, steered by the registered grant so only the owner sees them.
  always_comb begin
    bus.req_ack_o  = '0;
    bus.req_fin_o  = '0;
    bus.rsp_vld_o  = '0;
    bus.rsp_pkt_o  = bus.arb_rsp_pkt_i;
    bus.rsp_type_o = bus.arb_rsp_type_i;
    case (state_r)
      IDLE: begin
        bus.req_ack_o = '0;
      end
      ISSUE: begin
        bus.req_ack_o = bus.arb_ack_i     ? grant_r : '0;
        bus.req_fin_o = done_s            ? grant_r : '0;
        bus.rsp_vld_o = bus.arb_rsp_vld_i ? grant_r : '0;
      end
      WAIT_FIN: begin
        bus.req_fin_o = done_s            ? grant_r : '0;
        bus.rsp_vld_o = bus.arb_rsp_vld_i ? grant_r : '0;
      end
      default: begin
        bus.req_ack_o = '0;
      end
    endcase
  end

  // Grant, captured packet, round-robin pointer and registered bus outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_r  <= '0;
      gnt_idx_r <= '0;
      pkt_r     <= 32'd0;
      grant_r   <= '0;
      arb_vld_r <= 1'b0;
      stray_r   <= 1'b0;
    end else begin
      if ((state_r == IDLE) && sel_found_s) begin
        gnt_idx_r <= sel_idx_s;
        grant_r   <= ONE_HOT0 << sel_idx_s;
        pkt_r     <= bus.req_pkt_i[sel_idx_s];
      end else if (done_s) begin
        grant_r  <= '0;
        rr_ptr_r <= wrap_idx(gnt_idx_r, 1);
      end
      arb_vld_r <= (state_nxt_s == ISSUE);
      stray_r   <= stray_r | ((state_r == IDLE) && (bus.arb_rsp_vld_i || bus.arb_fin_i));
    end
  end

  assign bus.grant_o     = grant_r;
  assign bus.arb_vld_o   = arb_vld_r;
  assign bus.arb_pkt_o   = pkt_r;
  assign bus.stray_rsp_o = stray_r;

endmodule
